// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses the master modport and the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             perf_clr;

    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, mem_ready, perf_clr,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_wb_flush, mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, mem_ready, perf_clr,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
               id_ex_flush, mem_wb_flush, mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait freeze, redirect flush, load-use stall,
// memory timeout detection and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_W = WCNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              r_timeout;
    logic              w_timeout_set;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_mem_wait;
    logic w_load_use;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_stall;
    logic w_ex_mem_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_mem_wb_flush;

    assign w_mem_wait = bus.mem_req & ~bus.mem_ready;
    assign w_load_use = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                        ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                         (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        w_state_nxt    = r_state;
        w_wcnt_nxt     = r_wcnt;
        w_timeout_set  = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_mem_wait) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_wcnt_nxt  = WCNT_W'(1);
                end else begin
                    w_wcnt_nxt  = '0;
                end
            end
            S_MEM_WAIT: begin
                if (!w_mem_wait) begin
                    w_state_nxt = S_RUN;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == TIMEOUT_W) begin
                    w_state_nxt   = S_ERROR;
                    w_timeout_set = 1'b1;
                end else begin
                    w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
                end
            end
            S_ERROR: w_state_nxt = S_ERROR;
            default: begin
                w_state_nxt = S_RUN;
                w_wcnt_nxt  = '0;
            end
        endcase

        // A timed-out pipeline stays frozen exactly like a pending memory wait.
        if ((r_state == S_ERROR) || w_mem_wait) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_stall  = 1'b1;
            w_ex_mem_stall = 1'b1;
            w_mem_wb_flush = 1'b1;
        end else if (bus.ex_redirect) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_flush  = 1'b1;
        end

        if (!reset_n) begin
            w_pc_stall     = 1'b0;
            w_if_id_stall  = 1'b0;
            w_id_ex_stall  = 1'b0;
            w_ex_mem_stall = 1'b0;
            w_if_id_flush  = 1'b0;
            w_id_ex_flush  = 1'b0;
            w_mem_wb_flush = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_wcnt      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_timeout_set) begin
                r_timeout <= 1'b1;
            end
            if (bus.perf_clr) begin
                r_stall_cnt <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                if ((w_if_id_flush || w_id_ex_flush) && (r_flush_cnt != {CNT_W{1'b1}})) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pc_stall     = w_pc_stall;
    assign bus.if_id_stall  = w_if_id_stall;
    assign bus.id_ex_stall  = w_id_ex_stall;
    assign bus.ex_mem_stall = w_ex_mem_stall;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.mem_timeout  = r_timeout;
    assign bus.stall_count  = r_stall_cnt;
    assign bus.flush_count  = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with a short timeout and 4-bit counters,
// so timeout and counter saturation are reached within a few dozen cycles.
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam logic [6:0] V_IDLE  = 7'b0000000;
    localparam logic [6:0] V_FREEZE = 7'b1111001;
    localparam logic [6:0] V_REDIR = 7'b0000110;
    localparam logic [6:0] V_LDUSE = 7'b1100010;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (CNT_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Control outputs packed as {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, mem_wb flushes}.
    function automatic logic [6:0] ctrlVec();
        return {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
    endfunction

    // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic ld, input logic redir, input logic req,
                                 input logic rdy, input logic clr);
        @(negedge clock);
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_uses_rs1 = u1;
        bus.id_uses_rs2 = u2;
        bus.ex_rd       = rd;
        bus.ex_mem_read = ld;
        bus.ex_redirect = redir;
        bus.mem_req     = req;
        bus.mem_ready   = rdy;
        bus.perf_clr    = clr;
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        stepEdge();
        stepEdge();
        checks++;
        if (bus.stall_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_stall_count got=%0d exp=0", bus.stall_count);
        end
        checks++;
        if (bus.flush_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_flush_count got=%0d exp=0", bus.flush_count);
        end
        checks++;
        if (bus.mem_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_timeout got=%b exp=0", bus.mem_timeout);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL idle_outputs got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        stepEdge();
    endtask

    task automatic test_load_use();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_LDUSE) begin
            errors++;
            $display("[TB] FAIL load_use_rs1 got=%b exp=%b", ctrlVec(), V_LDUSE);
        end
        stepEdge();
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL load_use_x0 got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        stepEdge();
        applyStimulus(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_LDUSE) begin
            errors++;
            $display("[TB] FAIL load_use_rs2 got=%b exp=%b", ctrlVec(), V_LDUSE);
        end
        stepEdge();
        applyStimulus(5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL load_use_unused_rs1 got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL no_load_match got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        stepEdge();
        checks++;
        if (bus.stall_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL load_use_stall_count got=%0d exp=2", bus.stall_count);
        end
        checks++;
        if (bus.flush_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL load_use_flush_count got=%0d exp=2", bus.flush_count);
        end
    endtask

    task automatic test_redirect();
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_REDIR) begin
            errors++;
            $display("[TB] FAIL redirect_over_load_use got=%b exp=%b", ctrlVec(), V_REDIR);
        end
        stepEdge();
        checks++;
        if (bus.flush_count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL redirect_flush_count got=%0d exp=3", bus.flush_count);
        end
        checks++;
        if (bus.stall_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL redirect_stall_count got=%0d exp=2", bus.stall_count);
        end
    endtask

    task automatic test_mem_wait();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepEdge();
        checks++;
        if ({bus.stall_count, bus.flush_count} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL perf_clr got=%h exp=00", {bus.stall_count, bus.flush_count});
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (ctrlVec() !== V_FREEZE) begin
                errors++;
                $display("[TB] FAIL mem_wait_cycle%0d got=%b exp=%b", i, ctrlVec(), V_FREEZE);
            end
            stepEdge();
        end
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ctrlVec() !== V_REDIR) begin
            errors++;
            $display("[TB] FAIL mem_complete_redirect got=%b exp=%b", ctrlVec(), V_REDIR);
        end
        stepEdge();
        checks++;
        if (bus.stall_count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL mem_wait_stall_count got=%0d exp=3", bus.stall_count);
        end
        checks++;
        if (bus.flush_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL mem_wait_flush_count got=%0d exp=1", bus.flush_count);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepEdge();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL mem_req_drop got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        stepEdge();
        checks++;
        if (bus.stall_count !== 4'd4) begin
            errors++;
            $display("[TB] FAIL mem_req_drop_stall_count got=%0d exp=4", bus.stall_count);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            stepEdge();
            checks++;
            if (bus.mem_timeout !== (i == 5)) begin
                errors++;
                $display("[TB] FAIL timeout_edge%0d got=%b exp=%b", i, bus.mem_timeout, (i == 5));
            end
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_FREEZE) begin
            errors++;
            $display("[TB] FAIL error_frozen got=%b exp=%b", ctrlVec(), V_FREEZE);
        end
        stepEdge();
        checks++;
        if ((ctrlVec() !== V_FREEZE) || (bus.mem_timeout !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL error_sticky got=%b/%b exp=%b/1", ctrlVec(), bus.mem_timeout, V_FREEZE);
        end
        reset_n = 1'b0;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrlVec() !== V_IDLE) begin
            errors++;
            $display("[TB] FAIL error_reset_outputs got=%b exp=%b", ctrlVec(), V_IDLE);
        end
        stepEdge();
        reset_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ((ctrlVec() !== V_IDLE) || (bus.mem_timeout !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL error_recover got=%b/%b exp=%b/0", ctrlVec(), bus.mem_timeout, V_IDLE);
        end
        stepEdge();
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            stepEdge();
            if ((i == 14) || (i == 15) || (i == 20)) begin
                checks++;
                if (bus.stall_count !== CNT_W'((i > 15) ? 15 : i)) begin
                    errors++;
                    $display("[TB] FAIL saturate_stall_edge%0d got=%0d exp=%0d", i, bus.stall_count,
                             (i > 15) ? 15 : i);
                end
            end
        end
        checks++;
        if (bus.flush_count !== 4'd15) begin
            errors++;
            $display("[TB] FAIL saturate_flush got=%0d exp=15", bus.flush_count);
        end
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepEdge();
        checks++;
        if (bus.stall_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL clr_during_stall got=%0d exp=0", bus.stall_count);
        end
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepEdge();
        checks++;
        if (bus.stall_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL count_after_clr got=%0d exp=1", bus.stall_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
